mem_xfer_ctrl: RTL and testbench
================================

Name: mem_xfer_ctrl

Overview:
- Memory-side sequencer that sources the data register's load interface.
- On a control-unit read request it runs a memory read handshake with wait states, drives the returned byte on data_on_dr, and pulses load_dr for exactly one cycle.
- On a write request it takes the register's output byte and writes it to memory.
- Sits between the control unit, the data register and the external memory port.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, data width; must match the data register width.
- TIMEOUT, 15, maximum wait cycles for mem_ready before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read request, sampled in IDLE only.
- wr_req  in  1  write request, sampled in IDLE only.
- addr_in  in  ADDR_W  transfer address, captured with the request.
- dr_on_data  in  DATA_W  write data from the data register, captured with wr_req.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_en  out  1  memory access strobe, held high for the whole access.
- mem_we  out  1  1 = write, 0 = read; valid while mem_en is high.
- mem_ready  in  1  memory completion; sampled while mem_en is high.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high.
- data_on_dr  out  DATA_W  byte presented to the data register.
- load_dr  out  1  one-cycle load strobe to the data register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse, for reads and writes.
- err  out  1  one-cycle timeout pulse, coincident with done.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 (mem_addr, mem_wdata, data_on_dr, mem_en, mem_we, load_dr, busy, done, err); wait counter 0.
- Reset asserted mid-access: next edge returns to IDLE and drops mem_en; no load_dr, done or err is produced.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - If wr_req is high at edge N: latch addr_in→mem_addr, dr_on_data→mem_wdata, set mem_we=1. Enter ACCESS; mem_en=1 and busy=1 from N+1.
  - Else if rd_req is high: same, but mem_we=0.
  - If wr_req and rd_req are both high, write wins and the read is dropped (not queued).
- ACCESS:
  - At the first edge where mem_ready=1: clear mem_en and mem_we, go to COMPLETE.
  - On a read, also register mem_rdata→data_on_dr at that same edge.
  - Otherwise the wait counter increments each cycle, saturating at 2^5-1.
  - Minimum latency: mem_ready high in the first ACCESS cycle gives done 2 cycles after the request edge.
- COMPLETE (exactly 1 cycle):
  - done=1.
  - load_dr=1 on reads only; data_on_dr is valid in the same cycle.
  - Next state is IDLE; wait counter cleared.
- Requests arriving while busy=1 are ignored (not queued). The control unit must hold the request until it sees done.
- data_on_dr holds its last read value until the next successful read. Writes and timeouts never change it.
- mem_addr and mem_wdata hold their values after an access; they are only meaningful while mem_en=1.
- mem_ready while mem_en=0 is ignored.
- Back-to-back: a request can be accepted in the IDLE cycle right after COMPLETE, so the maximum rate is one access per 3 cycles.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - In ACCESS, when the wait counter reaches TIMEOUT with mem_ready still low, drop mem_en and go to COMPLETE with err=1 and done=1.
  - load_dr stays 0 and data_on_dr is unchanged.
  - Timeout occurs TIMEOUT+1 cycles after entering ACCESS.
  - A mem_ready arriving on the same edge as the timeout takes priority: normal completion, no err.
- When not defined: ACCESS waits indefinitely; err is tied to 0 and the counter logic is removed.

Test Plan:
- Read, zero wait: rd_req with addr_in=0x3C; memory returns mem_ready=1, mem_rdata=0xA5 in the first ACCESS cycle → mem_en high 1 cycle, mem_we=0, mem_addr=0x3C, then data_on_dr=0xA5 with load_dr=1 and done=1 for exactly 1 cycle.
- Write, 3 wait states: wr_req, addr_in=0x10, dr_on_data=0x5A; mem_ready rises after 3 cycles → mem_en high 4 cycles with mem_we=1, mem_wdata=0x5A; done=1, load_dr=0, data_on_dr unchanged.
- Simultaneous request: rd_req=wr_req=1, addr_in=0x20 → write performed (mem_we=1); no load_dr; a rd_req raised while busy=1 is ignored.
- Reset mid-access: reset pulsed in the 2nd ACCESS cycle → next cycle mem_en=0, busy=0; no done or load_dr; data_on_dr=0x00.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=15): read with mem_ready held low → mem_en low after 16 ACCESS cycles; done=1 and err=1 together; load_dr=0; data_on_dr keeps its prior value 0xA5.
- Back-to-back: read (rdata 0x11) then a read at the next IDLE (rdata 0x22), zero wait → load_dr pulses 3 cycles apart; data_on_dr goes 0x11 then 0x22.

Source files
------------

// File: rtl/mem_xfer_ctrl.sv
// Memory-side transfer sequencer feeding the data register load interface.
// Optional macro MEM_TIMEOUT_EN adds a wait-state timeout with err pulse.
module mem_xfer_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] dr_on_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_on_dr,
    output logic              load_dr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] data_on_dr_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              load_dr_q;
    logic              busy_q;
    logic              done_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

    logic [4:0] cnt_q;
    logic       err_q;
`endif

    // Sequencer: accept a request, hold the strobe until ready, then pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            data_on_dr_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            load_dr_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            load_dr_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (wr_req || rd_req) begin
                        mem_addr_q  <= addr_in;
                        mem_wdata_q <= dr_on_data;
                        mem_we_q    <= wr_req;
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        load_dr_q <= ~mem_we_q;
                        if (!mem_we_q) begin
                            data_on_dr_q <= mem_rdata;
                        end
                        state_q   <= COMPLETE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == TO_CNT) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= COMPLETE;
                    end else if (cnt_q != 5'h1f) begin
                        cnt_q <= cnt_q + 5'd1;
                    end
`endif
                end
                COMPLETE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign data_on_dr = data_on_dr_q;
    assign load_dr    = load_dr_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Randomized self-checking bench for mem_xfer_ctrl against a
// transaction-level model (expected strobe length, data register byte).
module tb_mem_xfer_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic          wr_req;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] dr_on_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_en;
    logic          mem_we;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] data_on_dr;
    logic          load_dr;
    logic          busy;
    logic          done;
    logic          err;

    int            n_run  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    int            last_load = 0;
    logic [DW-1:0] exp_dr = '0;

    mem_xfer_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr_in   (addr_in),
        .dr_on_data(dr_on_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .data_on_dr(data_on_dr),
        .load_dr   (load_dr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; memory answers in the (waits+1)th strobe cycle.
    task automatic xfer(input bit wr, input bit rd, input logic [7:0] a,
                        input logic [7:0] wd, input int waits,
                        input logic [7:0] rdat, input bit hold_rd);
        bit is_wr;
        int en_n;
        is_wr      = wr;
        wr_req     = wr;
        rd_req     = rd;
        addr_in    = a;
        dr_on_data = wd;
        step();
        wr_req     = 1'b0;
        rd_req     = hold_rd;
        addr_in    = 8'($urandom);
        dr_on_data = 8'($urandom);
        n_run++;
        if ({mem_en, mem_we, busy, mem_addr} !== {1'b1, is_wr, 1'b1, a}) begin
            n_fail++;
            $display("FAIL accept: en/we/busy/addr=%b%b%b/%h want 1%b1/%h",
                     mem_en, mem_we, busy, mem_addr, is_wr, a);
        end
        if (is_wr) begin
            n_run++;
            if (mem_wdata !== wd) begin
                n_fail++;
                $display("FAIL wdata: got %h want %h", mem_wdata, wd);
            end
        end
        en_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_en !== 1'b1) break;
            en_n++;
            mem_ready = (en_n == waits + 1);
            mem_rdata = mem_ready ? rdat : 8'($urandom);
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = 8'($urandom);
        rd_req    = 1'b0;
        if (!is_wr) exp_dr = rdat;
        n_run++;
        if (en_n != waits + 1) begin
            n_fail++;
            $display("FAIL en_len: got %0d cycles want %0d", en_n, waits + 1);
        end
        n_run++;
        if ({done, load_dr, err, busy} !== {1'b1, !is_wr, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL complete: done/load/err/busy=%b%b%b%b want 1%b01",
                     done, load_dr, err, busy, !is_wr);
        end
        n_run++;
        if (data_on_dr !== exp_dr) begin
            n_fail++;
            $display("FAIL dr_data: got %h want %h", data_on_dr, exp_dr);
        end
        if (!is_wr) last_load = cyc;
        step();
        n_run++;
        if ({done, load_dr, err, busy, mem_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle: done/load/err/busy/en=%b%b%b%b%b want 00000",
                     done, load_dr, err, busy, mem_en);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        rd_req     = 1'b1;
        wr_req     = 1'b0;
        addr_in    = 8'h99;
        dr_on_data = 8'h66;
        mem_ready  = 1'b1;
        mem_rdata  = 8'hFF;
        step();
        step();
        step();
        n_run++;
        if ({mem_en, mem_we, load_dr, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: en/we/load/busy/done/err=%b%b%b%b%b%b want 0",
                     mem_en, mem_we, load_dr, busy, done, err);
        end
        n_run++;
        if ({mem_addr, mem_wdata, data_on_dr} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr/wdata/dr=%h/%h/%h want 0",
                     mem_addr, mem_wdata, data_on_dr);
        end
        rd_req    = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b0;
        exp_dr    = '0;
        step();
    endtask

    task automatic test_read_zero_wait();
        xfer(1'b0, 1'b1, 8'h3C, 8'h00, 0, 8'hA5, 1'b0);
    endtask

    task automatic test_write_waits();
        xfer(1'b1, 1'b0, 8'h10, 8'h5A, 3, 8'hEE, 1'b0);
    endtask

    task automatic test_simultaneous();
        xfer(1'b1, 1'b1, 8'h20, 8'hC3, 2, 8'h77, 1'b1);
    endtask

    task automatic test_back_to_back();
        int first;
        xfer(1'b0, 1'b1, 8'h01, 8'h00, 0, 8'h11, 1'b0);
        first = last_load;
        xfer(1'b0, 1'b1, 8'h02, 8'h00, 0, 8'h22, 1'b0);
        n_run++;
        if (last_load - first != 3) begin
            n_fail++;
            $display("FAIL b2b_gap: load_dr spacing %0d want 3", last_load - first);
        end
    endtask

    task automatic test_reset_mid();
        rd_req  = 1'b1;
        addr_in = 8'h55;
        step();
        rd_req  = 1'b0;
        step();
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        exp_dr  = '0;
        n_run++;
        if ({mem_en, busy, done, load_dr, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid: en/busy/done/load/err=%b%b%b%b%b want 0",
                     mem_en, busy, done, load_dr, err);
        end
        n_run++;
        if (data_on_dr !== exp_dr) begin
            n_fail++;
            $display("FAIL rst_mid_dr: got %h want %h", data_on_dr, exp_dr);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        n_run++;
        if ({mem_en, busy, done, load_dr} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: en/busy/done/load=%b%b%b%b want 0",
                     mem_en, busy, done, load_dr);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int en_n;
        rd_req    = 1'b1;
        addr_in   = 8'h77;
        mem_ready = 1'b0;
        step();
        rd_req = 1'b0;
        en_n   = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_en !== 1'b1) break;
            en_n++;
            mem_rdata = 8'($urandom);
            step();
        end
        n_run++;
        if (en_n != TO + 1) begin
            n_fail++;
            $display("FAIL to_len: got %0d cycles want %0d", en_n, TO + 1);
        end
        n_run++;
        if ({done, err, load_dr} !== 3'b110) begin
            n_fail++;
            $display("FAIL to_flags: done/err/load=%b%b%b want 110",
                     done, err, load_dr);
        end
        n_run++;
        if (data_on_dr !== exp_dr) begin
            n_fail++;
            $display("FAIL to_dr: got %h want %h", data_on_dr, exp_dr);
        end
        step();
        n_run++;
        if ({done, err, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL to_idle: done/err/busy=%b%b%b want 000", done, err, busy);
        end
    endtask
`endif

    task automatic test_random();
        int kind;
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 8'($urandom);
                step();
                mem_ready = 1'b0;
                n_run++;
                if ({mem_en, busy, done, load_dr} !== 4'b0 || data_on_dr !== exp_dr) begin
                    n_fail++;
                    $display("FAIL rnd_idle: en/busy/done/load=%b%b%b%b dr=%h want 0000 %h",
                             mem_en, busy, done, load_dr, data_on_dr, exp_dr);
                end
            end else begin
                xfer(kind != 0, kind != 1, 8'($urandom), 8'($urandom),
                     $urandom_range(0, 6), 8'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        addr_in    = '0;
        dr_on_data = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        test_reset();
        test_read_zero_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_write_waits();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
